// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: blank code, glyph table and pattern decoder.
package seg7_pkg;

  // All segments off on the active-low bus
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low glyphs indexed by nibble, bit6=g .. bit0=a
  localparam logic [6:0] SEG_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Returns {err, nibble}; unknown patterns give err=1 with nibble 0
  function automatic logic [4:0] seg_decode(input logic [6:0] pattern);
    logic [4:0] r;
    r = 5'h10;
    for (int i = 0; i < 16; i++) begin
      if (pattern == SEG_GLYPH[i]) r = {1'b0, 4'(i)};
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_lut.sv
// Combinational pattern to {err, nibble} lookup.
module seg7_lut
  import seg7_pkg::*;
(
  input  logic [6:0] pat,
  output logic [3:0] d4,
  output logic       err
);

  // Table lookup against the shared glyph set
  always_comb begin
    {err, d4} = seg_decode(pat);
  end

endmodule

// File: rtl/seg7_decode.sv
// Recovers digits from an active-low 7-segment bus, tolerating blanking frames,
// and hands each newly stable digit out over valid/ready.
// Optional: define SEG7_DECODE_OVF_EN to add the sticky overwrite flag port ovf.
module seg7_decode
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE   = 4,
  parameter int unsigned BLANK_TO = 16384
) (
  input  logic       c,
  input  logic       rst_n,
  input  logic [6:0] hex,
  input  logic       ready,
  output logic       valid,
  output logic [3:0] d4,
  output logic       err,
  output logic       on
`ifdef SEG7_DECODE_OVF_EN
  ,
  output logic       ovf
`endif
);

  localparam int unsigned BW = $clog2(BLANK_TO + 1);
  localparam logic [7:0]    STABLE_C = 8'(STABLE);
  localparam logic [BW-1:0] BLANK_C  = BW'(BLANK_TO);
  localparam logic [BW-1:0] BLANK_M1 = BW'(BLANK_TO - 1);

  logic [6:0]    s;
  logic [6:0]    cand;
  logic [6:0]    last;
  logic          has_last;
  logic [7:0]    cnt;
  logic [BW-1:0] bcnt;

  logic [3:0] lut_d4;
  logic       lut_err;
  logic       accept;
  logic       blank;
  logic       timeout;
  logic       hs;

  seg7_lut u_lut (
    .pat (cand),
    .d4  (lut_d4),
    .err (lut_err)
  );

  // Acceptance, blank detection and handshake decode
  always_comb begin
    accept  = (cnt == STABLE_C) && (!has_last || (cand != last));
    blank   = (s == SEG_BLANK);
    // Fires on the edge where the blank counter reaches BLANK_TO (and while saturated)
    timeout = blank && (bcnt >= BLANK_M1);
    hs      = valid && ready;
  end

  // Sample, stability tracking, emission and display-off detection
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      s        <= SEG_BLANK;
      cand     <= SEG_BLANK;
      last     <= SEG_BLANK;
      has_last <= 1'b0;
      cnt      <= 8'd0;
      bcnt     <= '0;
      valid    <= 1'b0;
      d4       <= 4'd0;
      err      <= 1'b0;
      on       <= 1'b0;
    end else begin
      s <= hex;
      if (blank) begin
        if (bcnt != BLANK_C) bcnt <= bcnt + BW'(1);
      end else begin
        bcnt <= '0;
        on   <= 1'b1;
        if (s != cand) begin
          cand <= s;
          cnt  <= 8'd1;
        end else if (cnt != STABLE_C) begin
          cnt <= cnt + 8'd1;
        end
      end
      if (accept) begin
        d4       <= lut_d4;
        err      <= lut_err;
        valid    <= 1'b1;
        last     <= cand;
        has_last <= 1'b1;
      end else if (hs) begin
        valid <= 1'b0;
      end
      // Display went dark: forget the last digit so it re-emits on return
      if (timeout) begin
        on       <= 1'b0;
        has_last <= 1'b0;
        cnt      <= 8'd0;
      end
    end
  end

`ifdef SEG7_DECODE_OVF_EN
  // Sticky flag for a digit overwritten before it was consumed
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (accept && valid && !ready) begin
      ovf <= 1'b1;
    end else if (hs) begin
      ovf <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_seg7_decode.sv
// Directed self-checking bench for seg7_decode (STABLE=4, BLANK_TO=16).
module tb_seg7_decode;

  localparam int unsigned STABLE   = 4;
  localparam int unsigned BLANK_TO = 16;

  logic       c;
  logic       rst_n;
  logic [6:0] hex;
  logic       ready;
  logic       valid;
  logic [3:0] d4;
  logic       err;
  logic       on;
`ifdef SEG7_DECODE_OVF_EN
  logic       ovf;
`endif

  int checks   = 0;
  int failures = 0;
  int hs_cnt   = 0;
  int hs_base;

  seg7_decode #(
    .STABLE   (STABLE),
    .BLANK_TO (BLANK_TO)
  ) dut (
    .c     (c),
    .rst_n (rst_n),
    .hex   (hex),
    .ready (ready),
    .valid (valid),
    .d4    (d4),
    .err   (err),
    .on    (on)
`ifdef SEG7_DECODE_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  initial c = 1'b0;
  always #5 c = ~c;

  // Count completed handshakes to detect extra or missing emissions
  always @(posedge c) begin
    if (valid && ready) hs_cnt <= hs_cnt + 1;
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge c);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    hex   = 7'h7F;
    ready = 1'b0;
    #12;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_d4", 32'(d4), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_on", 32'(on), 32'd0);
`ifdef SEG7_DECODE_OVF_EN
    chk("rst_ovf", 32'(ovf), 32'd0);
`endif

    // Digit 2 held: accepted on edge STABLE+2 counted from the first sample
    rst_n = 1'b1;
    hex   = 7'h24;
    step(5);
    chk("t1_valid_e5", 32'(valid), 32'd0);
    chk("t1_on_e5", 32'(on), 32'd1);
    step(1);
    chk("t1_valid_e6", 32'(valid), 32'd1);
    chk("t1_d4", 32'(d4), 32'd2);
    chk("t1_err", 32'(err), 32'd0);
    ready   = 1'b1;
    hs_base = hs_cnt;
    step(1);
    chk("t1_valid_drop", 32'(valid), 32'd0);
    step(3);
    chk("t1_no_reemit", 32'(valid), 32'd0);
    chk("t1_hs_once", 32'(hs_cnt - hs_base), 32'd1);

    // Digit 3 with 1 lit / 3 blank duty cycle: a single emission
    hs_base = hs_cnt;
    for (int i = 0; i < 40; i++) begin
      hex = (i % 4 == 0) ? 7'h30 : 7'h7F;
      step(1);
    end
    chk("t2_emit_once", 32'(hs_cnt - hs_base), 32'd1);
    chk("t2_d4", 32'(d4), 32'd3);
    chk("t2_on", 32'(on), 32'd1);

    // Digit C, display off after BLANK_TO blank samples, then re-emitted
    hex = 7'h46;
    step(8);
    chk("t3_d4", 32'(d4), 32'hC);
    hex = 7'h7F;
    step(BLANK_TO);
    chk("t3_on_before", 32'(on), 32'd1);
    step(1);
    chk("t3_on_fall", 32'(on), 32'd0);
    hs_base = hs_cnt;
    hex     = 7'h46;
    step(5);
    chk("t3_re_valid_e5", 32'(valid), 32'd0);
    step(1);
    chk("t3_re_valid_e6", 32'(valid), 32'd1);
    chk("t3_re_d4", 32'(d4), 32'hC);
    step(2);
    chk("t3_re_hs", 32'(hs_cnt - hs_base), 32'd1);
    chk("t3_re_on", 32'(on), 32'd1);

    // Non-glyph pattern flags err with nibble 0
    ready = 1'b0;
    hex   = 7'h55;
    step(6);
    chk("t4_valid", 32'(valid), 32'd1);
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_d4", 32'(d4), 32'd0);
    ready = 1'b1;
    step(1);
    chk("t4_valid_drop", 32'(valid), 32'd0);

    // Overwrite while stalled
    ready = 1'b0;
    hex   = 7'h79;
    step(6);
    chk("t5_valid_1", 32'(valid), 32'd1);
    chk("t5_d4_1", 32'(d4), 32'd1);
`ifdef SEG7_DECODE_OVF_EN
    chk("t5_ovf_0", 32'(ovf), 32'd0);
`endif
    hex = 7'h00;
    step(6);
    chk("t5_valid_8", 32'(valid), 32'd1);
    chk("t5_d4_8", 32'(d4), 32'd8);
    chk("t5_err_8", 32'(err), 32'd0);
`ifdef SEG7_DECODE_OVF_EN
    chk("t5_ovf_1", 32'(ovf), 32'd1);
`endif
    ready = 1'b1;
    step(1);
    ready = 1'b0;
    chk("t5_valid_clr", 32'(valid), 32'd0);
`ifdef SEG7_DECODE_OVF_EN
    chk("t5_ovf_clr", 32'(ovf), 32'd0);
`endif

    // Reset mid-stability (cnt=2), then while a digit is pending
    hex = 7'h12;
    step(3);
    rst_n = 1'b0;
    #1;
    chk("t6_rst1_valid", 32'(valid), 32'd0);
    chk("t6_rst1_d4", 32'(d4), 32'd0);
    chk("t6_rst1_on", 32'(on), 32'd0);
    step(1);
    rst_n = 1'b1;
    step(5);
    chk("t6_after1_e5", 32'(valid), 32'd0);
    step(1);
    chk("t6_after1_e6", 32'(valid), 32'd1);
    chk("t6_after1_d4", 32'(d4), 32'd5);
    rst_n = 1'b0;
    #1;
    chk("t6_rst2_valid", 32'(valid), 32'd0);
    chk("t6_rst2_d4", 32'(d4), 32'd0);
    chk("t6_rst2_err", 32'(err), 32'd0);
    chk("t6_rst2_on", 32'(on), 32'd0);
    step(1);
    rst_n = 1'b1;
    step(5);
    chk("t6_after2_e5", 32'(valid), 32'd0);
    step(1);
    chk("t6_after2_e6", 32'(valid), 32'd1);
    chk("t6_after2_d4", 32'(d4), 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
